dreidel_turn_ctrl: RTL and testbench
====================================

// Module: dreidel_turn_ctrl
// PURPOSE
//  Initiator side of the doGame/done/gameState handshake served by the dreidel action FSM.
//  On a turn request it raises doGame and waits for done.
//  It then applies the spun outcome to player and pot coin counts, drops doGame and reports the turn.
//  It also supplies the free-running random value that the action FSM consumes as randIn.
// PARAMETERS
//  COINS_W      8     width of coin counters
//  START_COINS  10    player coins after reset
//  START_POT    2     pot coins after reset
//  ANTE         1     coins the player pays into an empty pot after a turn
//  LFSR_SEED    8'hA5 LFSR reset value, must be nonzero
// PORTS
//  clk          in   1        system clock
//  resetn       in   1        synchronous reset, ACTIVE-HIGH (1 = reset)
//  start        in   1        turn request; sampled only in IDLE
//  done         in   1        from action FSM; high while it sits in DONE
//  gameState    in   4        action FSM state: 0 IDLE,1 SPIN,2 NUN,3 GIMEL,4 HAY,5 SHIN,6 DONE
//  doGame       out  1        level request to action FSM
//  randOut      out  2        lfsr[1:0], drives action FSM randIn
//  playerCoins  out  COINS_W  player coin count
//  potCoins     out  COINS_W  pot coin count
//  lastResult   out  4        outcome code (2..5) of the last completed turn, 0 before any turn
//  busy         out  1        high in every state except IDLE and OVER
//  turnDone     out  1        one-cycle pulse when a turn completes
//  gameOver     out  1        sticky; player could not pay SHIN or ANTE
// BEHAVIOUR
//  Reset values:
//   - doGame=0, busy=0, turnDone=0, gameOver=0, lastResult=0
//   - playerCoins=START_COINS, potCoins=START_POT, lfsr=LFSR_SEED, state=IDLE, outLatch=0
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4; shifts every cycle incl. during turns, not in reset.
//  outLatch: every cycle gameState is in 2..5, outLatch<=gameState.
//   - Needed because gameState already reads 6 when done rises.
//  FSM:
//   - IDLE: start=1 -> REQ (doGame=1 the next cycle). start ignored in all other states.
//   - REQ: doGame=1; on done=1 -> APPLY. outLatch is cleared on entry to REQ.
//   - APPLY (1 cycle, doGame=1): lastResult<=outLatch; update coins per table:
//     - NUN(2): no change.
//     - GIMEL(3): player+=pot, pot=0.
//     - HAY(4): take=(pot+1)>>1; player+=take; pot-=take.
//     - SHIN(5): player>0 -> player-=1, pot+=1; else gameOver=1.
//     - outLatch 0 (no outcome seen): treated as NUN, lastResult=0.
//     - Additions saturate at 2^COINS_W-1. A saturated player add still empties/halves the pot as above.
//     - Next state is RELEASE.
//   - RELEASE: doGame=0; wait done=0 -> REFILL.
//   - REFILL (1 cycle):
//     - pot==0 and player>=ANTE: player-=ANTE, pot+=ANTE.
//     - pot==0 and player<ANTE: gameOver=1.
//     - -> FIN.
//   - FIN: turnDone=1 for 1 cycle -> OVER if gameOver else IDLE.
//   - OVER: terminal, doGame=0, busy=0; left only by reset.
//  Latency: start high in IDLE at edge n -> doGame high after edge n+1.
//   - done seen at edge m -> coins updated after edge m+1.
//  Reset mid-turn: all state returns to reset values the next edge, doGame drops immediately.
//   - The action FSM sees doGame=0 and returns to IDLE by its own rules.
//  done already high in IDLE/REQ entry: accepted as completion (no edge detect).
// TESTING
//  1 Reset: hold resetn=1 2 cycles -> player=10, pot=2, doGame=0, busy=0, randOut=lfsr[1:0] of 8'hA5.
//  2 GIMEL: start; model drives 1,1,3,6 with done on 6 -> player=12, pot=0.
//    Then REFILL gives player=11, pot=1, lastResult=3, one turnDone pulse.
//  3 HAY odd pot: pot=5, player=10, outcome 4 -> player=13, pot=2.
//    doGame low within 2 cycles of done.
//  4 SHIN broke: player=0, pot=3, outcome 5 -> gameOver=1, state OVER, later start ignored.
//  5 Saturation: player=250, pot=9, outcome 3 -> player=255, pot=0 then refill to 254/1.
//  6 Reset mid-REQ: resetn=1 while doGame=1 -> next cycle doGame=0, coins back to 10/2, no turnDone.

Source files
------------

// File: rtl/dreidel_turn_ctrl.sv
// ---------------------------------------------------------------------------
// dreidel_turn_ctrl
//
// Initiator side of the doGame/done/gameState handshake served by the dreidel
// action FSM. A turn request raises doGame. The block waits for done, applies
// the spun outcome to the player and pot coin counts, drops doGame, tops up an
// empty pot with the ante and then pulses turnDone. It also runs a free-running
// 8-bit LFSR whose low two bits feed the action FSM's randIn.
//
// Handshake: doGame is a level request. It stays high from REQ through APPLY.
// The action FSM holds done high while it sits in DONE. This block treats
// done=1 in REQ as completion with no edge detection, so a stale done is also
// accepted. The block then drops doGame and waits for done to fall before it
// finishes the turn.
//
// Ports
//   clk          in   1        system clock
//   resetn       in   1        synchronous reset, active-high (1 = reset)
//   start        in   1        turn request, sampled only in IDLE
//   done         in   1        action FSM is in DONE
//   gameState    in   4        action FSM state (2..5 = NUN/GIMEL/HAY/SHIN, 6 = DONE)
//   doGame       out  1        level request to the action FSM
//   randOut      out  2        lfsr[1:0], drives the action FSM randIn
//   playerCoins  out  COINS_W  player coin count
//   potCoins     out  COINS_W  pot coin count
//   lastResult   out  4        outcome code of the last completed turn (0 = none)
//   busy         out  1        high in every state except IDLE and OVER
//   turnDone     out  1        one-cycle pulse when a turn completes
//   gameOver     out  1        sticky; the player could not pay SHIN or the ante
//   dbg_state_o  out  3        current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module dreidel_turn_ctrl #(
  parameter int unsigned COINS_W     = 8,
  parameter int unsigned START_COINS = 10,
  parameter int unsigned START_POT   = 2,
  parameter int unsigned ANTE        = 1,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               done,
  input  logic [3:0]         gameState,
  output logic               doGame,
  output logic [1:0]         randOut,
  output logic [COINS_W-1:0] playerCoins,
  output logic [COINS_W-1:0] potCoins,
  output logic [3:0]         lastResult,
  output logic               busy,
  output logic               turnDone,
  output logic               gameOver,
  output logic [2:0]         dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_APPLY   = 3'd2,
    S_RELEASE = 3'd3,
    S_REFILL  = 3'd4,
    S_FIN     = 3'd5,
    S_OVER    = 3'd6
  } state_e;

  localparam logic [COINS_W-1:0] START_C = COINS_W'(START_COINS);
  localparam logic [COINS_W-1:0] POT_C   = COINS_W'(START_POT);
  localparam logic [COINS_W-1:0] ANTE_C  = COINS_W'(ANTE);

  state_e               state_q;
  logic [7:0]           lfsr_q;
  logic [3:0]           out_latch_q;
  logic [COINS_W-1:0]   player_q;
  logic [COINS_W-1:0]   pot_q;
  logic [3:0]           last_result_q;
  logic                 do_game_q;
  logic                 busy_q;
  logic                 turn_done_q;
  logic                 game_over_q;

  logic                 lfsr_fb;
  logic [COINS_W-1:0]   hay_take;
  logic                 outcome_visible;

  // Fibonacci taps 8,6,5,4 (bits 7,5,4,3).
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // HAY takes half the pot, rounded up: (pot+1)>>1 == (pot>>1) + pot[0].
  assign hay_take = {1'b0, pot_q[COINS_W-1:1]} + {{(COINS_W-1){1'b0}}, pot_q[0]};

  // The outcome is visible only while the action FSM is in NUN..SHIN. By the
  // time done rises, gameState already reads DONE, so the outcome is latched.
  assign outcome_visible = (gameState >= 4'd2) && (gameState <= 4'd5);

  function automatic logic [COINS_W-1:0] sat_add(input logic [COINS_W-1:0] a,
                                                 input logic [COINS_W-1:0] b);
    logic [COINS_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COINS_W] ? {COINS_W{1'b1}} : s[COINS_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      out_latch_q   <= 4'd0;
      player_q      <= START_C;
      pot_q         <= POT_C;
      last_result_q <= 4'd0;
      do_game_q     <= 1'b0;
      busy_q        <= 1'b0;
      turn_done_q   <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      lfsr_q      <= {lfsr_q[6:0], lfsr_fb};
      turn_done_q <= 1'b0;
      // doGame follows the state one cycle late, so it rises one cycle after
      // REQ is entered and falls one cycle after APPLY is left.
      do_game_q   <= (state_q == S_REQ) || (state_q == S_APPLY);

      if ((state_q == S_IDLE) && start) begin
        out_latch_q <= 4'd0;
      end else if (outcome_visible) begin
        out_latch_q <= gameState;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_REQ;
            busy_q  <= 1'b1;
          end
        end
        S_REQ: begin
          if (done) state_q <= S_APPLY;
        end
        S_APPLY: begin
          last_result_q <= out_latch_q;
          case (out_latch_q)
            4'd3: begin
              player_q <= sat_add(player_q, pot_q);
              pot_q    <= '0;
            end
            4'd4: begin
              player_q <= sat_add(player_q, hay_take);
              pot_q    <= pot_q - hay_take;
            end
            4'd5: begin
              if (player_q != '0) begin
                player_q <= player_q - 1'b1;
                pot_q    <= sat_add(pot_q, {{(COINS_W-1){1'b0}}, 1'b1});
              end else begin
                game_over_q <= 1'b1;
              end
            end
            default: ; // NUN, or no outcome seen: coins unchanged
          endcase
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!done) state_q <= S_REFILL;
        end
        S_REFILL: begin
          if (pot_q == '0) begin
            if (player_q >= ANTE_C) begin
              player_q <= player_q - ANTE_C;
              pot_q    <= sat_add(pot_q, ANTE_C);
            end else begin
              game_over_q <= 1'b1;
            end
          end
          turn_done_q <= 1'b1;
          state_q     <= S_FIN;
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= game_over_q ? S_OVER : S_IDLE;
        end
        S_OVER: ; // terminal until reset
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign doGame      = do_game_q;
  assign randOut     = lfsr_q[1:0];
  assign playerCoins = player_q;
  assign potCoins    = pot_q;
  assign lastResult  = last_result_q;
  assign busy        = busy_q;
  assign turnDone    = turn_done_q;
  assign gameOver    = game_over_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dreidel_turn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dreidel_turn_ctrl
//
// Plays the action FSM side of the handshake against dreidel_turn_ctrl.
// A second instance, with a near-full player purse, covers saturation.
// Expected coin counts, outcomes and LFSR bits come from a behavioural model
// of the game rules.
// ---------------------------------------------------------------------------
module tb_dreidel_turn_ctrl;

  localparam int MAXC = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn    = 1'b1;
  logic       start     = 1'b0;
  logic       start2    = 1'b0;
  logic       done      = 1'b0;
  logic [3:0] game_state = 4'd0;

  logic       do1, do2, bz1, bz2, td1, td2, go1, go2;
  logic [1:0] rnd1, rnd2;
  logic [7:0] pl1, pl2, pt1, pt2;
  logic [3:0] lr1, lr2;
  logic [2:0] st1, st2;

  dreidel_turn_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .done(done), .gameState(game_state),
    .doGame(do1), .randOut(rnd1), .playerCoins(pl1), .potCoins(pt1),
    .lastResult(lr1), .busy(bz1), .turnDone(td1), .gameOver(go1), .dbg_state_o(st1)
  );

  dreidel_turn_ctrl #(.START_COINS(250), .START_POT(9)) dut_sat (
    .clk(clk), .resetn(resetn), .start(start2), .done(done), .gameState(game_state),
    .doGame(do2), .randOut(rnd2), .playerCoins(pl2), .potCoins(pt2),
    .lastResult(lr2), .busy(bz2), .turnDone(td2), .gameOver(go2), .dbg_state_o(st2)
  );

  // Select which instance is under test.
  logic sel = 1'b0;
  wire       o_do  = sel ? do2 : do1;
  wire       o_bz  = sel ? bz2 : bz1;
  wire       o_td  = sel ? td2 : td1;
  wire       o_go  = sel ? go2 : go1;
  wire [1:0] o_rnd = sel ? rnd2 : rnd1;
  wire [7:0] o_pl  = sel ? pl2 : pl1;
  wire [7:0] o_pt  = sel ? pt2 : pt1;
  wire [3:0] o_lr  = sel ? lr2 : lr1;

  // ---------------- reference model ----------------
  int   m_player, m_pot, m_last;
  bit   m_over;
  logic [7:0] m_lfsr;

  // LFSR model: the feedback is the parity of the tapped bits 8,6,5,4.
  always @(posedge clk) begin
    if (resetn) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
  end

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    m_player = sel ? 250 : 10;
    m_pot    = sel ? 9 : 2;
    m_last   = 0;
    m_over   = 0;
  endtask

  task automatic model_apply(input int outcome);
    int take;
    m_last = outcome;
    case (outcome)
      3: begin m_player = sat(m_player + m_pot); m_pot = 0; end
      4: begin take = (m_pot + 1) / 2; m_player = sat(m_player + take); m_pot = m_pot - take; end
      5: begin
        if (m_player > 0) begin m_player = m_player - 1; m_pot = sat(m_pot + 1); end
        else m_over = 1;
      end
      default: ;
    endcase
  endtask

  task automatic model_refill();
    if (m_pot == 0) begin
      if (m_player >= 1) begin m_player = m_player - 1; m_pot = m_pot + 1; end
      else m_over = 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_player"}, 32'(o_pl), 32'(m_player));
    chk({tag, "_pot"},    32'(o_pt), 32'(m_pot));
    chk({tag, "_last"},   32'(o_lr), 32'(m_last));
    chk({tag, "_over"},   32'(o_go), 32'(m_over));
    chk({tag, "_rand"},   32'(o_rnd), 32'(m_lfsr[1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    resetn = 1'b1;
    start = 1'b0; start2 = 1'b0; done = 1'b0; game_state = 4'd0;
    step(); step();
    model_reset();
    chk("rst_player", 32'(o_pl), 32'(m_player));
    chk("rst_pot",    32'(o_pt), 32'(m_pot));
    chk("rst_dogame", 32'(o_do), 0);
    chk("rst_busy",   32'(o_bz), 0);
    chk("rst_rand",   32'(o_rnd), 32'd1);   // 8'hA5 -> low bits 01
    resetn = 1'b0;
  endtask

  task automatic pulse_start();
    if (sel) start2 = 1'b1; else start = 1'b1;
    step();
    start = 1'b0; start2 = 1'b0;
  endtask

  // One turn as the action FSM would play it. outcome 0 means the spin never
  // showed an outcome state before DONE.
  task automatic run_turn(input int outcome, input int spin_cycles);
    int k;
    int pulses;
    if (m_over) begin
      pulse_start();
      for (int i = 0; i < 4; i++) begin
        chk("over_ign_dogame", 32'(o_do), 0);
        chk("over_ign_busy", 32'(o_bz), 0);
        step();
      end
      check_state("over");
      return;
    end
    pulse_start();
    chk("req_lat0", 32'(o_do), 0);
    chk("req_busy", 32'(o_bz), 1);
    step();
    chk("req_lat1", 32'(o_do), 1);
    game_state = 4'd1;
    repeat (spin_cycles) step();
    if (outcome != 0) begin
      game_state = 4'(outcome);
      step();
    end
    game_state = 4'd6;
    done = 1'b1;
    step(); step();
    model_apply(outcome);
    chk("apply_player", 32'(o_pl), 32'(m_player));
    chk("apply_pot",    32'(o_pt), 32'(m_pot));
    chk("apply_last",   32'(o_lr), 32'(m_last));
    k = 2;
    while (o_do && k < 10) begin
      step();
      k++;
    end
    chk("release_lat", 32'(k), 32'd3);
    done = 1'b0;
    game_state = 4'd0;
    pulses = 0;
    repeat (6) begin
      step();
      if (o_td) pulses++;
    end
    model_refill();
    chk("turn_pulses", 32'(pulses), 32'd1);
    chk("end_busy", 32'(o_bz), 0);
    check_state("turn");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int oc;
    // Reset
    sel = 1'b0;
    do_reset();

    // GIMEL with a 1,1,3,6 action sequence
    run_turn(3, 2);
    chk("gimel_player", 32'(o_pl), 32'd11);
    chk("gimel_pot",    32'(o_pt), 32'd1);
    chk("gimel_last",   32'(o_lr), 32'd3);

    // HAY on an odd pot: three SHINs bring 10/2 to 7/5, then HAY takes 3
    do_reset();
    run_turn(5, 1); run_turn(5, 1); run_turn(5, 1);
    chk("pre_hay_pot", 32'(o_pt), 32'd5);
    run_turn(4, 1);
    chk("hay_player", 32'(o_pl), 32'd10);
    chk("hay_pot",    32'(o_pt), 32'd2);

    // Outcome never seen: behaves as NUN, lastResult 0
    run_turn(0, 2);
    chk("none_last", 32'(o_lr), 32'd0);

    // Randomized turns
    do_reset();
    for (int t = 0; t < 25; t++) begin
      oc = $urandom_range(0, 8);
      oc = (oc == 0) ? 0 : 2 + (oc % 4);
      run_turn(oc, $urandom_range(0, 3));
    end

    // Reset while the request is outstanding
    do_reset();
    pulse_start();
    step();
    chk("midreq_dogame_hi", 32'(o_do), 1);
    resetn = 1'b1;
    step();
    chk("midreq_dogame", 32'(o_do), 0);
    chk("midreq_player", 32'(o_pl), 32'd10);
    chk("midreq_pot",    32'(o_pt), 32'd2);
    chk("midreq_busy",   32'(o_bz), 0);
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midreq_no_td", 32'(o_td), 0);
      step();
    end

    // Saturation on the rich-player instance
    sel = 1'b1;
    do_reset();
    run_turn(3, 1);
    chk("sat_player", 32'(o_pl), 32'd254);
    chk("sat_pot",    32'(o_pt), 32'd1);
    sel = 1'b0;

    // SHIN while broke: spend all ten coins, then one more SHIN
    do_reset();
    for (int i = 0; i < 10; i++) run_turn(5, 1);
    chk("broke_player", 32'(o_pl), 32'd0);
    chk("broke_pot",    32'(o_pt), 32'd12);
    run_turn(5, 1);
    chk("broke_over", 32'(o_go), 32'd1);
    run_turn(3, 1);   // the start is ignored once the game is over
    chk("broke_player_kept", 32'(o_pl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
